fp_mul_ieee32: RTL and testbench

- Single-precision IEEE-754 floating-point multiplier with five selectable rounding modes.
- Takes two binary32 operands and produces their rounded product, plus overflow and underflow flags.
- Combinational datapath feeding one output register stage.
- Serves as the arithmetic core behind the design's top-level wrapper.

---
 rtl/fp_mul_pkg.sv | 31 +++
 rtl/fp_mul_ieee32_if.sv | 11 +
 rtl/fp_round.sv | 32 +++
 rtl/fp_mul_ieee32.sv | 71 +++++++
 tb/tb_fp_mul_ieee32.sv | 109 ++++++++++
 5 files changed

// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared constants, rounding-mode enum and operand unpacking for fp_mul_ieee32.
package fp_mul_pkg;
    localparam int BIAS = 127;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [30:0] MAXF = 31'h7F7FFFFF;
    typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RNA = 3'd4} rmode_e;
    typedef struct packed {
        logic sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_t;
    // Subnormal inputs count as zero: they are flushed before the multiply.
    function automatic fp_t unpack(input logic [31:0] v);
        fp_t f;
        f.sign = v[31];
        f.exp = v[30:23];
        f.man = v[22:0];
        f.is_zero = v[30:23] == 8'd0;
        f.is_inf = &v[30:23] && v[22:0] == 23'd0;
        f.is_nan = &v[30:23] && |v[22:0];
        return f;
    endfunction
    function automatic rmode_e to_mode(input logic [2:0] m);
        return m > 3'd4 ? RNE : rmode_e'(m);
    endfunction
endpackage

// File: rtl/fp_mul_ieee32_if.sv
// fp_mul_ieee32_if: operand/result bundle of the binary32 multiplier.
interface fp_mul_ieee32_if;
    logic [2:0] r_mode;
    logic [31:0] fp_X;
    logic [31:0] fp_Y;
    logic [31:0] fp_Z;
    logic ovrf;
    logic udrf;
    modport master(output r_mode, fp_X, fp_Y, input fp_Z, ovrf, udrf);
    modport slave(input r_mode, fp_X, fp_Y, output fp_Z, ovrf, udrf);
endinterface

// File: rtl/fp_round.sv
// fp_round: applies the rounding increment, renormalises on carry-out and flags exponent range errors.
module fp_round
    import fp_mul_pkg::*;
(
    input  logic sign,
    input  logic [MAN_W-1:0] man,
    input  logic g,
    input  logic r,
    input  logic s,
    input  logic signed [9:0] exp,
    input  rmode_e mode,
    output logic [MAN_W-1:0] man_o,
    output logic [EXP_W-1:0] exp_o,
    output logic ovf,
    output logic udf
);
    logic inc;
    logic [MAN_W:0] sum;
    logic signed [9:0] e;
    always_comb begin
        inc = mode == RNE ? g & (r | s | man[0]) :
              mode == RNA ? g :
              mode == RUP ? (g | r | s) & ~sign :
              mode == RDN ? (g | r | s) & sign : 1'b0;
        sum = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        man_o = sum[MAN_W-1:0];
        e = exp + $signed({9'd0, sum[MAN_W]});
        ovf = e >= 10'sd255;
        udf = e <= 10'sd0;
        exp_o = e[EXP_W-1:0];
    end
endmodule

// File: rtl/fp_mul_ieee32.sv
// fp_mul_ieee32: binary32 multiplier, five rounding modes, registered result with ovrf/udrf.
// Define FP_MUL_IN_REG_EN to add an input register stage (latency 2 instead of 1).
module fp_mul_ieee32
    import fp_mul_pkg::*;
#(
    parameter int PIPE_OUT = 1
) (
    input logic clk,
    input logic rst_n,
    fp_mul_ieee32_if.slave bus
);
    if (PIPE_OUT != 1) begin : g_bad_pipe
        $error("fp_mul_ieee32 supports only PIPE_OUT=1");
    end
    logic [31:0] x, y;
    logic [2:0] rm;
`ifdef FP_MUL_IN_REG_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {x, y, rm} <= '0;
        else {x, y, rm} <= {bus.fp_X, bus.fp_Y, bus.r_mode};
`else
    assign x = bus.fp_X;
    assign y = bus.fp_Y;
    assign rm = bus.r_mode;
`endif
    fp_t a, b;
    rmode_e mode;
    logic sign, g, r, s, special, inf_sel;
    logic [47:0] p;
    logic signed [9:0] e;
    logic [MAN_W-1:0] m, rnd_man;
    logic [EXP_W-1:0] rnd_exp;
    logic ovf, udf;
    logic [31:0] z;
    always_comb begin
        a = unpack(x);
        b = unpack(y);
        mode = to_mode(rm);
        sign = a.sign ^ b.sign;
        p = {1'b1, a.man} * {1'b1, b.man};
        e = $signed({2'b0, a.exp}) + $signed({2'b0, b.exp}) - $signed(10'(BIAS)) + $signed({9'd0, p[47]});
        m = p[47] ? p[46:24] : p[45:23];
        g = p[47] ? p[23] : p[22];
        r = p[47] ? p[22] : p[21];
        s = p[47] ? |p[21:0] : |p[20:0];
    end
    fp_round u_round (
        .sign(sign), .man(m), .g(g), .r(r), .s(s), .exp(e), .mode(mode),
        .man_o(rnd_man), .exp_o(rnd_exp), .ovf(ovf), .udf(udf)
    );
    // Overflow saturates to inf only when the mode rounds away from zero in the result's direction.
    always_comb begin
        inf_sel = mode == RNE || mode == RNA || (mode == RUP && !sign) || (mode == RDN && sign);
        special = a.is_nan | b.is_nan | a.is_inf | b.is_inf | a.is_zero | b.is_zero;
        z = a.is_nan | b.is_nan | (a.is_zero & b.is_inf) | (a.is_inf & b.is_zero) ? QNAN :
            a.is_inf | b.is_inf ? {sign, 8'hFF, 23'd0} :
            a.is_zero | b.is_zero ? {sign, 31'd0} :
            ovf ? {sign, inf_sel ? 31'h7F800000 : MAXF} :
            udf ? {sign, 31'd0} : {sign, rnd_exp, rnd_man};
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.fp_Z <= '0;
            bus.ovrf <= 1'b0;
            bus.udrf <= 1'b0;
        end else begin
            bus.fp_Z <= z;
            bus.ovrf <= ~special & ovf;
            bus.udrf <= ~special & udf;
        end
endmodule

// File: tb/tb_fp_mul_ieee32.sv
// tb_fp_mul_ieee32: directed vectors streamed one per cycle, plus async reset checks.
module tb_fp_mul_ieee32;
`ifdef FP_MUL_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        string tag;
        logic [31:0] x, y;
        logic [2:0] m;
        logic [31:0] z;
        logic o, u;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int failures = 0;
    vec_t v[$];
    fp_mul_ieee32_if bus();
    fp_mul_ieee32 dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got z/o/u=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input string tag, input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       input logic [31:0] z, input logic o, input logic u);
        vec_t t;
        t.tag = tag; t.x = x; t.y = y; t.m = m; t.z = z; t.o = o; t.u = u;
        v.push_back(t);
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m);
        bus.fp_X = x;
        bus.fp_Y = y;
        bus.r_mode = m;
    endtask

    initial begin
        drive(32'h40B00000, 32'hC0100000, 3'd0);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {bus.fp_Z, bus.ovrf, bus.udrf}, 34'd0);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold", {bus.fp_Z, bus.ovrf, bus.udrf}, 34'd0);
        add("basic_rne", 32'h40B00000, 32'hC0100000, 3'd0, 32'hC1460000, 0, 0);
        add("basic_rtz", 32'h40B00000, 32'hC0100000, 3'd1, 32'hC1460000, 0, 0);
        add("basic_rup", 32'h40B00000, 32'hC0100000, 3'd3, 32'hC1460000, 0, 0);
        add("basic_m7", 32'h40B00000, 32'hC0100000, 3'd7, 32'hC1460000, 0, 0);
        add("inx_rne", 32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 0, 0);
        add("inx_rtz", 32'h3F800001, 32'h3F800001, 3'd1, 32'h3F800002, 0, 0);
        add("inx_rup", 32'h3F800001, 32'h3F800001, 3'd3, 32'h3F800003, 0, 0);
        add("inx_rdn", 32'h3F800001, 32'h3F800001, 3'd2, 32'h3F800002, 0, 0);
        add("ninx_rdn", 32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800003, 0, 0);
        add("ninx_rup", 32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800002, 0, 0);
        add("tie_rne", 32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 0, 0);
        add("tie_rna", 32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 0, 0);
        add("carry_rne", 32'h3F800001, 32'h3FFFFFFE, 3'd0, 32'h40000000, 0, 0);
        add("carry_rtz", 32'h3F800001, 32'h3FFFFFFE, 3'd1, 32'h3FFFFFFF, 0, 0);
        add("ovf_rne", 32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 1, 0);
        add("ovf_rtz", 32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 1, 0);
        add("ovf_rup", 32'h7F000000, 32'h40000000, 3'd3, 32'h7F800000, 1, 0);
        add("ovf_rdn", 32'h7F000000, 32'h40000000, 3'd2, 32'h7F7FFFFF, 1, 0);
        add("ovf_rna", 32'h7F000000, 32'h40000000, 3'd4, 32'h7F800000, 1, 0);
        add("novf_rup", 32'hFF000000, 32'h40000000, 3'd3, 32'hFF7FFFFF, 1, 0);
        add("novf_rdn", 32'hFF000000, 32'h40000000, 3'd2, 32'hFF800000, 1, 0);
        add("novf_m6", 32'hFF000000, 32'h40000000, 3'd6, 32'hFF800000, 1, 0);
        add("udf_pos", 32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 0, 1);
        add("udf_neg", 32'h80800000, 32'h3F000000, 3'd0, 32'h80000000, 0, 1);
        add("udf_rup", 32'h00800000, 32'h3F000000, 3'd3, 32'h00000000, 0, 1);
        add("min_norm", 32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 0, 0);
        add("zero_inf", 32'h00000000, 32'h7F800000, 3'd0, 32'h7FC00000, 0, 0);
        add("inf_neg", 32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 0, 0);
        add("nan_in", 32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 0, 0);
        add("nan_zero", 32'h7F800001, 32'h00000000, 3'd0, 32'h7FC00000, 0, 0);
        add("zero_neg", 32'h00000000, 32'hC0400000, 3'd0, 32'h80000000, 0, 0);
        add("sub_flush", 32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 0, 0);
        add("nsub_flush", 32'h80000001, 32'h3F800000, 3'd0, 32'h80000000, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < v.size() + LAT - 1; i++) begin
            @(negedge clk);
            if (i < v.size()) drive(v[i].x, v[i].y, v[i].m);
            @(posedge clk);
            #1;
            if (i - LAT + 1 >= 0 && i - LAT + 1 < v.size())
                chk(v[i-LAT+1].tag, {bus.fp_Z, bus.ovrf, bus.udrf},
                    {v[i-LAT+1].z, v[i-LAT+1].o, v[i-LAT+1].u});
        end
        @(negedge clk);
        drive(32'h7F000000, 32'h40000000, 3'd0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid", {bus.fp_Z, bus.ovrf, bus.udrf}, 34'd0);
        drive(32'h40B00000, 32'hC0100000, 3'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_released", {bus.fp_Z, bus.ovrf, bus.udrf}, 34'd0);
        repeat (LAT) @(posedge clk);
        #1 chk("after_rst", {bus.fp_Z, bus.ovrf, bus.udrf}, {32'hC1460000, 2'b00});
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
